// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - iterative shift-add multiplier datapath, one partial product per step
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   cnt;

  // product already includes the pending partial, so the final step's value can be captured on that edge
  assign product = acc + (b_sh[0] ? a_sh : '0);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (start) begin
      acc  <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      cnt  <= '0;
    end else if (step) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshakes and an iterative multiplier
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 busy
);

  state_t state_q, state_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_step;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_carry;
  logic [WIDTH:0]       sum;
  logic                 shamt_ok;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign mul_step  = (state_q == S_BUSY);
  assign sum       = {1'b0, a} + {1'b0, b};
  assign shamt_ok  = (b < WIDTH'(WIDTH));

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .product (product),
    .last    (mul_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (opcode == OP_MUL) ? S_BUSY : S_DONE;
      S_BUSY:  if (mul_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res[WIDTH-1:0] = a - b;
        alu_carry          = (a < b);
      end
      OP_AND:  alu_res[WIDTH-1:0] = a & b;
      OP_OR:   alu_res[WIDTH-1:0] = a | b;
      OP_XOR:  alu_res[WIDTH-1:0] = a ^ b;
      OP_SHL:  alu_res[WIDTH-1:0] = shamt_ok ? (a << b) : '0;
      OP_SHR:  alu_res[WIDTH-1:0] = shamt_ok ? (a >> b) : '0;
      default: alu_res = '0;
    endcase
  end

  // result/flags only change on a capture, which keeps them stable under backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept && (opcode != OP_MUL)) begin
      result <= alu_res;
      carry  <= alu_carry;
      zero   <= (alu_res == '0);
    end else if (mul_step && mul_last) begin
      result <= product;
      carry  <= 1'b0;
      zero   <= (product == '0);
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu against an arithmetic model
module tb_seq_alu;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     opcode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model(input int op, input int x, input int y,
                                output int res, output int cy);
    int m;
    m  = (1 << W) - 1;
    cy = 0;
    case (op)
      0: begin res = x + y; cy = (x + y) >> W; end
      1: begin res = (x - y + (1 << W)) % (1 << W); cy = (x < y) ? 1 : 0; end
      2: res = x * y;
      3: res = x & y;
      4: res = x | y;
      5: res = x ^ y;
      6: res = (y >= W) ? 0 : ((x << y) & m);
      default: res = (y >= W) ? 0 : (x >> y);
    endcase
  endfunction

  task automatic run_op(input int op, input int x, input int y, input int hold, input string tag);
    int exp_r, exp_c, lat, busy_n;
    model(op, x, y, exp_r, exp_c);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    a         = W'(x);
    b         = W'(y);
    opcode    = 3'(op);
    out_ready = (hold == 0);
    lat = 0;
    busy_n = 0;
    // keep in_valid asserted with junk operands while the op is in flight
    do begin
      @(negedge clk);
      lat++;
      if (busy && !out_valid) busy_n++;
      a      = W'($urandom);
      b      = W'($urandom);
      opcode = 3'($urandom);
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check({tag, ".latency"}, lat, (op == 2) ? W + 1 : 1);
    check({tag, ".busy_cycles"}, busy_n, (op == 2) ? W : 0);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".carry"}, carry, exp_c);
    check({tag, ".zero"}, zero, (exp_r == 0) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".held_result"}, result, exp_r);
      check({tag, ".held_valid"}, out_valid, 1);
      check({tag, ".held_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_in_ready"}, in_ready, 1);
    out_ready = 1'($urandom);
  endtask

  initial begin
    int ov_seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    check("rst.carry", carry, 0);
    check("rst.zero", zero, 0);
    check("rst.busy", busy, 0);
    reset = 1'b1;

    run_op(0, 8'hC8, 8'h64, 0, "add");
    run_op(1, 8'h03, 8'h05, 0, "sub_borrow");
    run_op(1, 8'h42, 8'h42, 0, "sub_zero");
    run_op(2, 8'hFF, 8'hFF, 0, "mul_ff");
    run_op(5, 8'hF0, 8'h3C, 5, "xor_bp");
    run_op(6, 8'h81, 1, 0, "shl");
    run_op(7, 8'h81, 8, 0, "shr_wide");
    run_op(2, 0, 8'h37, 2, "mul_zero");

    // reset in the 4th BUSY cycle of a multiply
    @(negedge clk);
    in_valid  = 1'b1;
    opcode    = 3'd2;
    a         = 8'hFF;
    b         = 8'hFF;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst.busy_before", busy, 1);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst.out_valid", out_valid, 0);
    check("mid_rst.busy", busy, 0);
    check("mid_rst.result", result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ov_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("mid_rst.no_stale", ov_seen, 0);
    check("mid_rst.in_ready", in_ready, 1);

    for (int n = 0; n < 150; n++) begin
      int op, x, y;
      op = $urandom_range(0, 7);
      x  = $urandom_range(0, 255);
      y  = (op >= 6) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      run_op(op, x, y, $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
